// File: rtl/decoder_seq.sv
// decoder_seq: registered N-to-2^N one-hot decoder with direct (valid/ready) and auto-scan modes.
// Optional macro DECODER_SEQ_BLANK_EN inserts one blank cycle between scan positions. Rev 1.0
`default_nettype none

module decoder_seq #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_n,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  sel_ready,
  output logic [(2**SEL_W)-1:0] y,
  output logic                  y_valid,
  output logic                  scan_wrap
);

  localparam int NOUT = 2**SEL_W;
  localparam int DW   = $clog2(DWELL + 1);

  localparam logic [DW-1:0]    c_DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SEL_W-1:0] c_IDX_LAST   = {SEL_W{1'b1}};
  localparam logic [NOUT-1:0]  c_ONE        = NOUT'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_idx;
  logic [DW-1:0]    r_dwell;
  logic [NOUT-1:0]  r_y;
  logic             r_y_valid;
  logic             r_sel_ready;
  logic             r_scan_wrap;
`ifdef DECODER_SEQ_BLANK_EN
  logic             r_blank;
`endif

  logic [SEL_W-1:0] w_idx_next;
  logic             w_pos_last;

  assign w_idx_next = r_idx + 1'b1;
  assign w_pos_last = (r_dwell == c_DWELL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_dwell     <= '0;
      r_y         <= '0;
      r_y_valid   <= 1'b0;
      r_sel_ready <= 1'b0;
      r_scan_wrap <= 1'b0;
`ifdef DECODER_SEQ_BLANK_EN
      r_blank     <= 1'b0;
`endif
    end else if (en_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_dwell     <= '0;
      r_y         <= '0;
      r_y_valid   <= 1'b0;
      r_sel_ready <= 1'b0;
      r_scan_wrap <= 1'b0;
`ifdef DECODER_SEQ_BLANK_EN
      r_blank     <= 1'b0;
`endif
    end else if (!mode) begin
      r_state     <= S_DIRECT;
      r_sel_ready <= 1'b1;
      r_scan_wrap <= 1'b0;
      r_idx       <= '0;
      r_dwell     <= '0;
`ifdef DECODER_SEQ_BLANK_EN
      r_blank     <= 1'b0;
`endif
      // Entering DIRECT blanks the output; only an accepted select lights it.
      if (r_state != S_DIRECT) begin
        r_y       <= '0;
        r_y_valid <= 1'b0;
      end else if (sel_valid && r_sel_ready) begin
        r_y       <= c_ONE << sel;
        r_y_valid <= 1'b1;
      end
    end else begin
      r_state     <= S_SCAN;
      r_sel_ready <= 1'b0;
      if (r_state != S_SCAN) begin
        r_idx       <= '0;
        r_dwell     <= '0;
        r_y         <= c_ONE;
        r_y_valid   <= 1'b1;
        r_scan_wrap <= 1'b0;
`ifdef DECODER_SEQ_BLANK_EN
        r_blank     <= 1'b0;
      end else if (r_blank) begin
        r_blank     <= 1'b0;
        r_idx       <= w_idx_next;
        r_y         <= c_ONE << w_idx_next;
        r_y_valid   <= 1'b1;
        r_scan_wrap <= (r_idx == c_IDX_LAST);
      end else if (w_pos_last) begin
        // Break-before-make gap; dwell already rewound for the next position.
        r_blank     <= 1'b1;
        r_dwell     <= '0;
        r_y         <= '0;
        r_y_valid   <= 1'b0;
        r_scan_wrap <= 1'b0;
`else
      end else if (w_pos_last) begin
        r_dwell     <= '0;
        r_idx       <= w_idx_next;
        r_y         <= c_ONE << w_idx_next;
        r_y_valid   <= 1'b1;
        r_scan_wrap <= (r_idx == c_IDX_LAST);
`endif
      end else begin
        r_dwell     <= r_dwell + 1'b1;
        r_scan_wrap <= 1'b0;
      end
    end
  end

  assign sel_ready = r_sel_ready;
  assign y         = r_y;
  assign y_valid   = r_y_valid;
  assign scan_wrap = r_scan_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed-vector bench for decoder_seq at SEL_W=2, DWELL=3.
`default_nettype none

module tb_decoder_seq;

  localparam int SEL_W = 2;
  localparam int DWELL = 3;
`ifdef DECODER_SEQ_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam int PER_POS = BLANK ? DWELL + 1 : DWELL;
  localparam int PERIOD  = 4 * PER_POS;

  logic             clk;
  logic             rst_n;
  logic             en_n;
  logic             mode;
  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic             sel_ready;
  logic [3:0]       y;
  logic             y_valid;
  logic             scan_wrap;

  int n_vectors;
  int n_miscompares;

  decoder_seq #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_n      (en_n),
    .mode      (mode),
    .sel_valid (sel_valid),
    .sel       (sel),
    .sel_ready (sel_ready),
    .y         (y),
    .y_valid   (y_valid),
    .scan_wrap (scan_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected scan output for the c-th cycle after SCAN entry.
  function automatic logic [3:0] exp_scan_y(input int c);
    logic [3:0] one;
    one = 4'b0001;
    if (BLANK && (c % PER_POS) == DWELL) return 4'b0000;
    return one << ((c / PER_POS) % 4);
  endfunction

  task automatic check_scan(input int c);
    logic [3:0] ey;
    ey = exp_scan_y(c);
    check_eq($sformatf("scan_y[c=%0d]", c), y, ey);
    check_eq($sformatf("scan_yv[c=%0d]", c), y_valid, (ey != 4'b0000));
    check_eq($sformatf("scan_wrap[c=%0d]", c), scan_wrap, (c >= PERIOD) && (c % PERIOD == 0));
    check_eq($sformatf("scan_ready[c=%0d]", c), sel_ready, 1'b0);
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst_n     = 1'b0;
    en_n      = 1'b1;
    mode      = 1'b0;
    sel_valid = 1'b0;
    sel       = '0;

    tick();
    tick();
    check_eq("rst_y", y, 4'b0000);
    check_eq("rst_yv", y_valid, 1'b0);
    check_eq("rst_ready", sel_ready, 1'b0);
    check_eq("rst_wrap", scan_wrap, 1'b0);

    rst_n = 1'b1;
    tick();
    check_eq("idle_ready", sel_ready, 1'b0);

    // Direct decode.
    en_n = 1'b0;
    mode = 1'b0;
    tick();
    check_eq("dir_entry_ready", sel_ready, 1'b1);
    check_eq("dir_entry_y", y, 4'b0000);
    check_eq("dir_entry_yv", y_valid, 1'b0);

    sel = 2'd2; sel_valid = 1'b1;
    tick();
    check_eq("dir_sel2_y", y, 4'b0100);
    check_eq("dir_sel2_yv", y_valid, 1'b1);

    sel = 2'd3; sel_valid = 1'b0;
    tick();
    check_eq("dir_hold1_y", y, 4'b0100);
    tick();
    check_eq("dir_hold2_y", y, 4'b0100);

    sel = 2'd0; sel_valid = 1'b1;
    tick();
    check_eq("dir_b2b0_y", y, 4'b0001);
    sel = 2'd1;
    tick();
    check_eq("dir_b2b1_y", y, 4'b0010);
    check_eq("dir_b2b1_yv", y_valid, 1'b1);

    // Auto-scan across two full periods; select traffic must be ignored.
    sel = 2'd3; sel_valid = 1'b1;
    mode = 1'b1;
    tick();
    for (int c = 0; c <= 2 * PERIOD; c++) begin
      check_scan(c);
      tick();
    end

    // Enable drop mid-scan, then restart and drop again during position 2.
    en_n = 1'b1;
    tick();
    check_eq("drop0_y", y, 4'b0000);
    en_n = 1'b0;
    tick();
    for (int c = 0; c <= 2 * PER_POS; c++) begin
      check_scan(c);
      if (c < 2 * PER_POS) tick();
    end
    en_n = 1'b1;
    tick();
    check_eq("drop_y", y, 4'b0000);
    check_eq("drop_yv", y_valid, 1'b0);
    check_eq("drop_wrap", scan_wrap, 1'b0);
    check_eq("drop_ready", sel_ready, 1'b0);
    en_n = 1'b0;
    tick();
    check_scan(0);
    tick();
    check_scan(1);

    // SCAN -> DIRECT: a select offered on the switch edge is not accepted.
    mode = 1'b0; sel = 2'd1; sel_valid = 1'b1;
    tick();
    check_eq("sw_y", y, 4'b0000);
    check_eq("sw_yv", y_valid, 1'b0);
    check_eq("sw_ready", sel_ready, 1'b1);
    check_eq("sw_wrap", scan_wrap, 1'b0);
    tick();
    check_eq("sw_sel1_y", y, 4'b0010);
    sel = 2'd3;
    tick();
    check_eq("sw_sel3_y", y, 4'b1000);
    check_eq("sw_sel3_yv", y_valid, 1'b1);
    sel_valid = 1'b0;

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_y", y, 4'b0000);
    check_eq("arst_yv", y_valid, 1'b0);
    check_eq("arst_ready", sel_ready, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

`default_nettype wire
